// File: rtl/nf10_rr_input_arbiter.sv
// nf10_rr_input_arbiter
//   Merges five AXI4-Stream ingress ports into one egress stream. Each port
//   feeds a 4-entry fall-through FIFO, and one whole packet at a time is
//   forwarded from the port chosen by a packet-granular round-robin search.
//   Packets are never interleaved on the egress stream.
//
// Ports
//   axi_aclk, axi_reset        clock, asynchronous active-high reset
//   s_axis_*_0..4              ingress streams (tdata/tstrb/tuser/tvalid/tlast in, tready out)
//   m_axis_*                   egress stream (tdata/tstrb/tuser/tvalid/tlast out, tready in)
//
// Build option
//   NF10_ARB_SRC_PORT_STAMP_EN  when defined, m_axis_tuser[23:16] carries a
//                               one-hot code of the source port; otherwise
//                               tuser passes through untouched.
//
// fallthrough_small_fifo (same file)
//   Small FIFO whose head entry is readable combinationally as soon as it is
//   written. nearly_full asserts at NEARLY_FULL entries.

module fallthrough_small_fifo #(
   parameter int WIDTH          = 8,
   parameter int MAX_DEPTH_BITS = 2,
   parameter int NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             nearly_full,
   output logic             empty
);
   localparam int DEPTH = 2**MAX_DEPTH_BITS;
   localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE  = 1;
   localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE  = 1;
   localparam logic [MAX_DEPTH_BITS:0]   CNT_FULL = DEPTH;
   localparam logic [MAX_DEPTH_BITS:0]   CNT_NF   = NEARLY_FULL;

   logic [WIDTH-1:0]          mem_q [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [MAX_DEPTH_BITS:0]   count_q, count_d;
   logic                      wr_ok, rd_ok;

   always_comb begin
      wr_ok    = wr_en & (count_q != CNT_FULL);
      rd_ok    = rd_en & (count_q != '0);
      wr_ptr_d = wr_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= din;
   end

   assign dout        = mem_q[rd_ptr_q];
   assign empty       = (count_q == '0);
   assign nearly_full = (count_q >= CNT_NF);
endmodule

// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | searching cur_queue+1.. for a non-empty FIFO; no egress beat
// ST_WR_PKT | forwarding the packet at the head of FIFO[cur_queue]
module nf10_rr_input_arbiter #(
   parameter int C_AXIS_DATA_WIDTH = 256,
   parameter int C_USER_WIDTH      = 128,
   parameter int NUM_QUEUES        = 5
) (
   input  logic                           axi_aclk,
   input  logic                           axi_reset,

   input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_0,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_0,
   input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_0,
   input  logic                           s_axis_tvalid_0,
   output logic                           s_axis_tready_0,
   input  logic                           s_axis_tlast_0,

   input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_1,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_1,
   input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_1,
   input  logic                           s_axis_tvalid_1,
   output logic                           s_axis_tready_1,
   input  logic                           s_axis_tlast_1,

   input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_2,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_2,
   input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_2,
   input  logic                           s_axis_tvalid_2,
   output logic                           s_axis_tready_2,
   input  logic                           s_axis_tlast_2,

   input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_3,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_3,
   input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_3,
   input  logic                           s_axis_tvalid_3,
   output logic                           s_axis_tready_3,
   input  logic                           s_axis_tlast_3,

   input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_4,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_4,
   input  logic [C_USER_WIDTH-1:0]        s_axis_tuser_4,
   input  logic                           s_axis_tvalid_4,
   output logic                           s_axis_tready_4,
   input  logic                           s_axis_tlast_4,

   output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic [C_USER_WIDTH-1:0]        m_axis_tuser,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast
);
   localparam int STRB_W  = C_AXIS_DATA_WIDTH / 8;
   localparam int ENTRY_W = 1 + C_USER_WIDTH + STRB_W + C_AXIS_DATA_WIDTH;
   localparam logic [2:0] LAST_QUEUE = 3'(NUM_QUEUES - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_WR_PKT = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              cur_queue_q, cur_queue_d;

   logic [ENTRY_W-1:0]      fifo_din  [NUM_QUEUES];
   logic [ENTRY_W-1:0]      fifo_dout [NUM_QUEUES];
   logic [NUM_QUEUES-1:0]   in_tvalid, in_tready;
   logic [NUM_QUEUES-1:0]   fifo_wr, fifo_rd, fifo_nf, fifo_empty;

   logic [ENTRY_W-1:0]      head;
   logic                    head_tlast;
   logic [C_USER_WIDTH-1:0] head_tuser;
   logic                    found;
   logic [3:0]              cand;

   assign fifo_din[0] = {s_axis_tlast_0, s_axis_tuser_0, s_axis_tstrb_0, s_axis_tdata_0};
   assign fifo_din[1] = {s_axis_tlast_1, s_axis_tuser_1, s_axis_tstrb_1, s_axis_tdata_1};
   assign fifo_din[2] = {s_axis_tlast_2, s_axis_tuser_2, s_axis_tstrb_2, s_axis_tdata_2};
   assign fifo_din[3] = {s_axis_tlast_3, s_axis_tuser_3, s_axis_tstrb_3, s_axis_tdata_3};
   assign fifo_din[4] = {s_axis_tlast_4, s_axis_tuser_4, s_axis_tstrb_4, s_axis_tdata_4};

   assign in_tvalid = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2,
                       s_axis_tvalid_1, s_axis_tvalid_0};

   // tready is forced low while reset is held so nothing lands in a FIFO
   // that is being cleared.
   assign in_tready = ~fifo_nf & {NUM_QUEUES{~axi_reset}};
   assign fifo_wr   = in_tvalid & in_tready;

   assign s_axis_tready_0 = in_tready[0];
   assign s_axis_tready_1 = in_tready[1];
   assign s_axis_tready_2 = in_tready[2];
   assign s_axis_tready_3 = in_tready[3];
   assign s_axis_tready_4 = in_tready[4];

   for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_in_fifo
      fallthrough_small_fifo #(
         .WIDTH          (ENTRY_W),
         .MAX_DEPTH_BITS (2)
      ) u_fifo (
         .clk         (axi_aclk),
         .reset       (axi_reset),
         .din         (fifo_din[i]),
         .wr_en       (fifo_wr[i]),
         .rd_en       (fifo_rd[i]),
         .dout        (fifo_dout[i]),
         .nearly_full (fifo_nf[i]),
         .empty       (fifo_empty[i])
      );
   end

   assign head         = fifo_dout[cur_queue_q];
   assign head_tlast   = head[ENTRY_W-1];
   assign head_tuser   = head[ENTRY_W-2 -: C_USER_WIDTH];
   assign m_axis_tstrb = head[C_AXIS_DATA_WIDTH +: STRB_W];
   assign m_axis_tdata = head[C_AXIS_DATA_WIDTH-1:0];
   assign m_axis_tlast = head_tlast;

   always_comb begin
      m_axis_tuser = head_tuser;
`ifdef NF10_ARB_SRC_PORT_STAMP_EN
      m_axis_tuser[23:16] = 8'b1 << cur_queue_q;
`endif
   end

   always_comb begin
      state_d       = state_q;
      cur_queue_d   = cur_queue_q;
      fifo_rd       = '0;
      m_axis_tvalid = 1'b0;
      found         = 1'b0;
      cand          = '0;
      case (state_q)
         ST_IDLE: begin
            // Start one past the last served port so a busy port cannot
            // starve the others.
            for (int i = 1; i <= NUM_QUEUES; i++) begin
               cand = {1'b0, cur_queue_q} + 4'(i);
               if (cand >= 4'(NUM_QUEUES)) cand = cand - 4'(NUM_QUEUES);
               if (!found && !fifo_empty[cand[2:0]]) begin
                  found       = 1'b1;
                  cur_queue_d = cand[2:0];
               end
            end
            if (found) state_d = ST_WR_PKT;
         end
         ST_WR_PKT: begin
            // An empty source mid-packet just stalls; other ports wait.
            m_axis_tvalid        = ~fifo_empty[cur_queue_q];
            fifo_rd[cur_queue_q] = m_axis_tready & ~fifo_empty[cur_queue_q];
            if (m_axis_tready && !fifo_empty[cur_queue_q] && head_tlast)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         state_q     <= ST_IDLE;
         cur_queue_q <= LAST_QUEUE;
      end else begin
         state_q     <= state_d;
         cur_queue_q <= cur_queue_d;
      end
   end
endmodule
